// File: rtl/mem_op_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_op_ctrl : T-state controller for ld / ldi / st with memory wait states.
// Optional: MEM_TIMEOUT_EN adds a memory-wait timeout.  Revision: 1.0
// ---------------------------------------------------------------------------
module mem_op_ctrl #(
  parameter int               OPC_W     = 5,
  parameter logic [OPC_W-1:0] ADD_OP    = OPC_W'(5'b00011),
  parameter int               TO_CYCLES = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             IncPC,
  output logic             MARin,
  output logic             Zin,
  output logic             ZLowOut,
  output logic             PCin,
  output logic             Read,
  output logic             Write,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Grb,
  output logic             BAout,
  output logic             Yin,
  output logic             Cout,
  output logic             Gra,
  output logic             Rin,
  output logic             Rout,
  output logic [OPC_W-1:0] alu_op,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam logic [OPC_W-1:0] OP_LD  = '0;
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(2);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [OPC_W-1:0] op;
  logic             legal;
  logic             timeout;

  generate
    if (TO_CYCLES < 1) begin : g_to_check
      $error("TO_CYCLES must be at least 1");
    end
  endgenerate

  assign legal = (ir_opcode == OP_LD) || (ir_opcode == OP_LDI) || (ir_opcode == OP_ST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      op    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T3) op <= ir_opcode;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_wait;

  assign mem_wait = (state == S_T1) || ((state == S_T6) && (op == OP_LD)) ||
                    ((state == S_T7) && (op == OP_ST));
  assign timeout  = mem_wait && !mem_ready && (wait_cnt == CNT_W'(TO_CYCLES - 1));

  // Cleared on every state change, so each wait state starts from zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                         wait_cnt <= '0;
    else if (state_nxt != state)     wait_cnt <= '0;
    else if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    {PCout, IncPC, MARin, Zin, ZLowOut, PCin, Read, Write, MDRin} = '0;
    {MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout}         = '0;
    alu_op = '0;
    busy   = 1'b1;
    done   = 1'b0;
    fault  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_T0;
      end
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        state_nxt = S_T1;
      end
      S_T1: begin
        {ZLowOut, PCin, Read, MDRin} = '1;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        {MDRout, IRin} = '1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (legal) begin
          {Grb, BAout, Yin} = '1;
          state_nxt = S_T4;
        end else begin
          state_nxt = S_FAULT;
        end
      end
      S_T4: begin
        {Cout, Zin} = '1;
        alu_op    = ADD_OP;
        state_nxt = S_T5;
      end
      S_T5: begin
        ZLowOut = 1'b1;
        if (op == OP_LDI) begin
          {Gra, Rin, done} = '1;
          state_nxt = S_IDLE;
        end else begin
          MARin     = 1'b1;
          state_nxt = S_T6;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (op == OP_LD) begin
          Read = 1'b1;
          if (mem_ready) state_nxt = S_T7;
        end else begin
          {Gra, Rout} = '1;
          state_nxt = S_T7;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          {MDRout, Gra, Rin, done} = '1;
          state_nxt = S_IDLE;
        end else begin
          Write = 1'b1;
          if (mem_ready) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
    if (timeout) state_nxt = S_FAULT;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_op_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_op_ctrl : directed self-checking bench for mem_op_ctrl.  Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_op_ctrl;

  // Strobe bit positions follow the output port list order.
  localparam logic [17:0] B_PCOUT   = 18'd1 << 17;
  localparam logic [17:0] B_INCPC   = 18'd1 << 16;
  localparam logic [17:0] B_MARIN   = 18'd1 << 15;
  localparam logic [17:0] B_ZIN     = 18'd1 << 14;
  localparam logic [17:0] B_ZLOWOUT = 18'd1 << 13;
  localparam logic [17:0] B_PCIN    = 18'd1 << 12;
  localparam logic [17:0] B_READ    = 18'd1 << 11;
  localparam logic [17:0] B_WRITE   = 18'd1 << 10;
  localparam logic [17:0] B_MDRIN   = 18'd1 << 9;
  localparam logic [17:0] B_MDROUT  = 18'd1 << 8;
  localparam logic [17:0] B_IRIN    = 18'd1 << 7;
  localparam logic [17:0] B_GRB     = 18'd1 << 6;
  localparam logic [17:0] B_BAOUT   = 18'd1 << 5;
  localparam logic [17:0] B_YIN     = 18'd1 << 4;
  localparam logic [17:0] B_COUT    = 18'd1 << 3;
  localparam logic [17:0] B_GRA     = 18'd1 << 2;
  localparam logic [17:0] B_RIN     = 18'd1 << 1;
  localparam logic [17:0] B_ROUT    = 18'd1 << 0;

  localparam logic [17:0] X_T0    = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [17:0] X_T1    = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [17:0] X_T2    = B_MDROUT | B_IRIN;
  localparam logic [17:0] X_T3    = B_GRB | B_BAOUT | B_YIN;
  localparam logic [17:0] X_T4    = B_COUT | B_ZIN;
  localparam logic [17:0] X_T5LDI = B_ZLOWOUT | B_GRA | B_RIN;
  localparam logic [17:0] X_T5M   = B_ZLOWOUT | B_MARIN;
  localparam logic [17:0] X_T6LD  = B_READ | B_MDRIN;
  localparam logic [17:0] X_T6ST  = B_GRA | B_ROUT | B_MDRIN;
  localparam logic [17:0] X_T7LD  = B_MDROUT | B_GRA | B_RIN;
  localparam logic [17:0] X_T7ST  = B_WRITE;
  localparam logic [4:0]  ADD     = 5'b00011;

  logic       clk = 1'b0;
  logic       clr, start, mem_ready;
  logic [4:0] ir_opcode;
  logic PCout, IncPC, MARin, Zin, ZLowOut, PCin, Read, Write, MDRin;
  logic MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout;
  logic [4:0] alu_op;
  logic busy, done, fault;
  logic [25:0] obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_op_ctrl #(.OPC_W(5), .ADD_OP(5'b00011), .TO_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .start(start), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .ZLowOut(ZLowOut),
    .PCin(PCin), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Grb(Grb), .BAout(BAout), .Yin(Yin), .Cout(Cout), .Gra(Gra),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done), .fault(fault)
  );

  assign obs = {PCout, IncPC, MARin, Zin, ZLowOut, PCin, Read, Write, MDRin,
                MDRout, IRin, Grb, BAout, Yin, Cout, Gra, Rin, Rout,
                alu_op, busy, done, fault};

  task automatic expect_now(input string tag, input logic [17:0] es, input logic [4:0] ea,
                            input logic eb, input logic ed, input logic ef);
    logic [25:0] exp_v;
    exp_v = {es, ea, eb, ed, ef};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive inputs on the falling edge, then check the decoded outputs.
  task automatic step(input string tag, input logic st, input logic mr, input logic [4:0] opc,
                      input logic [17:0] es, input logic [4:0] ea,
                      input logic eb, input logic ed, input logic ef);
    @(negedge clk);
    start = st; mem_ready = mr; ir_opcode = opc;
    #1;
    expect_now(tag, es, ea, eb, ed, ef);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b1; ir_opcode = 5'd0;
    @(negedge clk); #1;
    expect_now("reset", 18'd0, 5'd0, 0, 0, 0);
    @(negedge clk); clr = 1'b0;

    // ld, memory always ready: done in cycle 8, add only in cycle 5
    step("ld_idle", 1, 1, 5'd0, 18'd0,   5'd0, 0, 0, 0);
    step("ld_t0",   0, 1, 5'd0, X_T0,    5'd0, 1, 0, 0);
    step("ld_t1",   0, 1, 5'd0, X_T1,    5'd0, 1, 0, 0);
    step("ld_t2",   1, 1, 5'd0, X_T2,    5'd0, 1, 0, 0);
    step("ld_t3",   0, 1, 5'd0, X_T3,    5'd0, 1, 0, 0);
    step("ld_t4",   0, 1, 5'd0, X_T4,    ADD,  1, 0, 0);
    step("ld_t5",   0, 1, 5'd0, X_T5M,   5'd0, 1, 0, 0);
    step("ld_t6",   0, 1, 5'd0, X_T6LD,  5'd0, 1, 0, 0);
    step("ld_t7",   0, 1, 5'd0, X_T7LD,  5'd0, 1, 1, 0);

    // start right after done; ld with three wait cycles in T1
    step("ldw_idle", 1, 1, 5'd0, 18'd0,  5'd0, 0, 0, 0);
    step("ldw_t0",   0, 1, 5'd0, X_T0,   5'd0, 1, 0, 0);
    step("ldw_t1a",  0, 0, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("ldw_t1b",  0, 0, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("ldw_t1c",  0, 0, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("ldw_t1d",  0, 1, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("ldw_t2",   0, 1, 5'd0, X_T2,   5'd0, 1, 0, 0);
    step("ldw_t3",   0, 1, 5'd0, X_T3,   5'd0, 1, 0, 0);
    step("ldw_t4",   0, 1, 5'd0, X_T4,   ADD,  1, 0, 0);
    step("ldw_t5",   0, 1, 5'd0, X_T5M,  5'd0, 1, 0, 0);
    step("ldw_t6",   0, 1, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("ldw_t7",   1, 1, 5'd0, X_T7LD, 5'd0, 1, 1, 0);
    step("ldw_after",0, 1, 5'd0, 18'd0,  5'd0, 0, 0, 0);

    // st, with one not-ready cycle in T7 holding Write
    step("st_idle", 1, 1, 5'd0, 18'd0,  5'd0, 0, 0, 0);
    step("st_t0",   0, 1, 5'd0, X_T0,   5'd0, 1, 0, 0);
    step("st_t1",   0, 1, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("st_t2",   0, 1, 5'd0, X_T2,   5'd0, 1, 0, 0);
    step("st_t3",   0, 1, 5'd2, X_T3,   5'd0, 1, 0, 0);
    step("st_t4",   0, 1, 5'd0, X_T4,   ADD,  1, 0, 0);
    step("st_t5",   0, 1, 5'd0, X_T5M,  5'd0, 1, 0, 0);
    step("st_t6",   0, 0, 5'd0, X_T6ST, 5'd0, 1, 0, 0);
    step("st_t7w",  0, 0, 5'd0, X_T7ST, 5'd0, 1, 0, 0);
    step("st_t7",   0, 1, 5'd0, X_T7ST, 5'd0, 1, 1, 0);

    // ldi: done in cycle 6, start during busy ignored
    step("ldi_idle", 1, 1, 5'd0, 18'd0,   5'd0, 0, 0, 0);
    step("ldi_t0",   1, 1, 5'd0, X_T0,    5'd0, 1, 0, 0);
    step("ldi_t1",   1, 1, 5'd0, X_T1,    5'd0, 1, 0, 0);
    step("ldi_t2",   0, 1, 5'd0, X_T2,    5'd0, 1, 0, 0);
    step("ldi_t3",   0, 1, 5'd1, X_T3,    5'd0, 1, 0, 0);
    step("ldi_t4",   1, 1, 5'd0, X_T4,    ADD,  1, 0, 0);
    step("ldi_t5",   0, 1, 5'd0, X_T5LDI, 5'd0, 1, 1, 0);
    step("ldi_after",0, 1, 5'd0, 18'd0,   5'd0, 0, 0, 0);

    // illegal opcode: sticky fault until clr
    step("ill_idle", 1, 1, 5'd0,  18'd0, 5'd0, 0, 0, 0);
    step("ill_t0",   0, 1, 5'd0,  X_T0,  5'd0, 1, 0, 0);
    step("ill_t1",   0, 1, 5'd0,  X_T1,  5'd0, 1, 0, 0);
    step("ill_t2",   0, 1, 5'd0,  X_T2,  5'd0, 1, 0, 0);
    step("ill_t3",   0, 1, 5'h1f, 18'd0, 5'd0, 1, 0, 0);
    step("ill_f1",   1, 1, 5'd0,  18'd0, 5'd0, 0, 0, 1);
    step("ill_f2",   0, 1, 5'd0,  18'd0, 5'd0, 0, 0, 1);
    step("ill_f3",   1, 1, 5'd0,  18'd0, 5'd0, 0, 0, 1);
    @(negedge clk); start = 1'b0; clr = 1'b1; #1;
    expect_now("ill_clr", 18'd0, 5'd0, 0, 0, 0);
    @(negedge clk); clr = 1'b0;

    // clr asserted in the middle of T4 clears outputs without a clock edge
    step("rst_idle", 1, 1, 5'd0, 18'd0, 5'd0, 0, 0, 0);
    step("rst_t0",   0, 1, 5'd0, X_T0,  5'd0, 1, 0, 0);
    step("rst_t1",   0, 1, 5'd0, X_T1,  5'd0, 1, 0, 0);
    step("rst_t2",   0, 1, 5'd0, X_T2,  5'd0, 1, 0, 0);
    step("rst_t3",   0, 1, 5'd0, X_T3,  5'd0, 1, 0, 0);
    step("rst_t4",   0, 1, 5'd0, X_T4,  ADD,  1, 0, 0);
    #1 clr = 1'b1; #1;
    expect_now("rst_async", 18'd0, 5'd0, 0, 0, 0);
    @(negedge clk); clr = 1'b0;
    step("rst_hold1", 0, 1, 5'd0, 18'd0, 5'd0, 0, 0, 0);
    step("rst_hold2", 0, 1, 5'd0, 18'd0, 5'd0, 0, 0, 0);
    step("rst_new",   1, 1, 5'd0, 18'd0, 5'd0, 0, 0, 0);
    step("rst_new0",  0, 1, 5'd0, X_T0,  5'd0, 1, 0, 0);

`ifdef MEM_TIMEOUT_EN
    // ld in progress: memory never ready in T6 -> fault after 4 cycles
    step("to_t1",  0, 1, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("to_t2",  0, 1, 5'd0, X_T2,   5'd0, 1, 0, 0);
    step("to_t3",  0, 1, 5'd0, X_T3,   5'd0, 1, 0, 0);
    step("to_t4",  0, 1, 5'd0, X_T4,   ADD,  1, 0, 0);
    step("to_t5",  0, 1, 5'd0, X_T5M,  5'd0, 1, 0, 0);
    step("to_w1",  0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("to_w2",  0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("to_w3",  0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("to_w4",  0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("to_flt", 0, 0, 5'd0, 18'd0,  5'd0, 0, 0, 1);
    @(negedge clk); clr = 1'b1; #1;
    expect_now("to_clr", 18'd0, 5'd0, 0, 0, 0);
    @(negedge clk); clr = 1'b0;
    // ready arrives in the last allowed cycle -> normal completion
    step("tr_idle", 1, 1, 5'd0, 18'd0,  5'd0, 0, 0, 0);
    step("tr_t0",   0, 1, 5'd0, X_T0,   5'd0, 1, 0, 0);
    step("tr_t1",   0, 1, 5'd0, X_T1,   5'd0, 1, 0, 0);
    step("tr_t2",   0, 1, 5'd0, X_T2,   5'd0, 1, 0, 0);
    step("tr_t3",   0, 1, 5'd0, X_T3,   5'd0, 1, 0, 0);
    step("tr_t4",   0, 1, 5'd0, X_T4,   ADD,  1, 0, 0);
    step("tr_t5",   0, 1, 5'd0, X_T5M,  5'd0, 1, 0, 0);
    step("tr_w1",   0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("tr_w2",   0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("tr_w3",   0, 0, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("tr_w4",   0, 1, 5'd0, X_T6LD, 5'd0, 1, 0, 0);
    step("tr_t7",   0, 1, 5'd0, X_T7LD, 5'd0, 1, 1, 0);
    step("tr_after",0, 1, 5'd0, 18'd0,  5'd0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
